alu_cmd_issuer: RTL and testbench
=================================

Name: alu_cmd_issuer

Overview:
- Upstream driver stage for the 8-bit registered sequential ALU (ports clk, a, b, op, c; one-cycle registered result; op 0=add, 1=sub, 2=and, 3=or).
- Accepts operand/opcode commands over a valid/ready handshake and drives the ALU inputs from registers.
- Tracks the ALU's one-cycle latency, captures each result into a result FIFO and returns it in order over a second valid/ready handshake.
- Adds a sequence tag and a zero flag to each result.

Parameters:
- RES_DEPTH, 4, result FIFO entries; power of 2, minimum 4.
- TAG_W, 3, width of the per-command sequence tag.

Ports:
- clk  in  1  rising-edge clock, shared with the ALU.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command can be accepted this cycle.
- cmd_a  in  8  operand A.
- cmd_b  in  8  operand B.
- cmd_op  in  2  ALU opcode.
- alu_a  out  8  to ALU a; registered.
- alu_b  out  8  to ALU b; registered.
- alu_op  out  2  to ALU op; registered.
- alu_c  in  8  from ALU c.
- res_valid  out  1  FIFO head valid.
- res_ready  in  1  consumer accepts head.
- res_data  out  8  result at FIFO head.
- res_tag  out  TAG_W  tag of the command that produced the head result.
- res_zero  out  1  res_data == 0, stored per entry.
- busy  out  1  s1_v | s2_v | (count != 0).

Behaviour:
- Reset (async, rst_n low):
  - alu_a, alu_b, alu_op, s1_v, s2_v, tag counter, FIFO pointers and count all go to 0.
  - res_valid, busy and res_zero are 0. res_data and res_tag read as 0.
- Credit rule:
  - cmd_ready = (count + s1_v + s2_v) < RES_DEPTH. It is computed from registered state only.
  - A pop in the same cycle does not return credit. This guarantees the FIFO never overflows.
- Accept (edge where cmd_valid && cmd_ready):
  - alu_a/alu_b/alu_op <= cmd_a/cmd_b/cmd_op.
  - s1_v <= 1; s1_tag <= tag counter; tag counter increments, wrapping 2^TAG_W-1 -> 0.
- No accept:
  - s1_v <= 0. alu_a/alu_b/alu_op hold their previous value.
- ALU stage:
  - Every edge: s2_v <= s1_v, s2_tag <= s1_tag.
  - The ALU samples alu_* on the same edge, so while s2_v=1, alu_c holds that command's result.
- Capture:
  - Every edge where s2_v=1, push {alu_c, s2_tag, alu_c==0} into the FIFO.
  - alu_c is ignored whenever s2_v=0.
- Latency:
  - Accept at edge E -> ALU result at E+1 -> FIFO push at E+2.
  - res_valid is high after E+2 if the FIFO was empty. No bypass.
- Throughput:
  - One command per cycle sustained while res_ready=1.
- Pop (edge where res_valid && res_ready):
  - Head advances. res_* outputs are combinational from the head entry.
  - res_data/res_tag/res_zero are stable while res_valid && !res_ready.
- FIFO boundary cases:
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Push into empty: visible next cycle.
  - Pointers wrap modulo RES_DEPTH.
- Arithmetic:
  - Performed by the ALU, modulo 2^8. This block does no arithmetic on data.
- Reset mid-operation:
  - In-flight commands (s1/s2) and FIFO contents are discarded; the tag restarts at 0.
  - The ALU has no reset, so its stale c is ignored because s2_v=0.
  - cmd_ready returns to 1 on the first cycle after rst_n deasserts.
- cmd_* may change while cmd_ready=0; it is sampled only on accept.

Test Plan:
1. Reset, then one command a=7, b=3, op=0 with res_ready=1 -> alu_a=7/alu_b=3/alu_op=0 after the accept edge; res_valid rises exactly 2 edges after accept with res_data=10, res_tag=0, res_zero=0; busy falls after the pop.
2. Back-to-back a=7, b=3, op=0,1,2,3, cmd_valid held, res_ready=1 -> cmd_ready stays 1; results on consecutive cycles: 10, 4, 3, 7; tags 0, 1, 2, 3.
3. Wrap and zero: a=3, b=7, op=1 -> res_data=0xFC, res_zero=0. Then a=5, b=5, op=1 -> res_data=0, res_zero=1.
4. Backpressure with res_ready=0 and 6 commands offered -> exactly 4 accepted (cmd_ready=0 once count+inflight=4); res_data held at the first result. Then res_ready=1 -> 4 results drain in order, the remaining 2 are accepted, 6 results total, tags 0..5, none lost or duplicated.
5. Tag wrap: 10 consecutive commands -> tags 0..7, 0, 1.
6. Assert rst_n low one cycle after an accept, with 2 results in the FIFO -> res_valid=0, busy=0 immediately (async). After release: no stale result appears; the next command gets tag 0 and its correct result.

Source files
------------

// File: rtl/alu_cmd_issuer.sv
// Command issuer for the 8-bit registered ALU: registers operands, tracks the one-cycle
// ALU latency and returns tagged results in order through a credit-protected FIFO.
module alu_cmd_issuer #(
  parameter int RES_DEPTH = 4,
  parameter int TAG_W     = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic [1:0]       cmd_op,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [1:0]       alu_op,
  input  logic [7:0]       alu_c,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_zero,
  output logic             busy
);
  localparam int AW = $clog2(RES_DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]       alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [1:0]       alu_op_q, alu_op_d;
  logic             s1_v_q, s1_v_d, s2_v_q, s2_v_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d, s2_tag_q, s2_tag_d;
  logic [TAG_W-1:0] tag_cnt_q, tag_cnt_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [7:0]       data_mem_q [RES_DEPTH];
  logic [7:0]       data_mem_d [RES_DEPTH];
  logic [TAG_W-1:0] tag_mem_q  [RES_DEPTH];
  logic [TAG_W-1:0] tag_mem_d  [RES_DEPTH];
  logic [RES_DEPTH-1:0] zero_mem_q, zero_mem_d;

  logic          accept, push, pop;
  logic [CW:0]   credit_used;

  // Credit counts in-flight commands so a pop never has to make room for a push.
  always_comb begin
    credit_used = {1'b0, count_q} + {{CW{1'b0}}, s1_v_q} + {{CW{1'b0}}, s2_v_q};
    cmd_ready   = credit_used < (CW+1)'(RES_DEPTH);
    res_valid   = (count_q != '0);
    accept      = cmd_valid && cmd_ready;
    push        = s2_v_q;
    pop         = res_valid && res_ready;
  end

  always_comb begin
    alu_a_d    = accept ? cmd_a  : alu_a_q;
    alu_b_d    = accept ? cmd_b  : alu_b_q;
    alu_op_d   = accept ? cmd_op : alu_op_q;
    s1_v_d     = accept;
    s1_tag_d   = accept ? tag_cnt_q : s1_tag_q;
    tag_cnt_d  = accept ? tag_cnt_q + TAG_W'(1) : tag_cnt_q;
    s2_v_d     = s1_v_q;
    s2_tag_d   = s1_tag_q;
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    data_mem_d = data_mem_q;
    tag_mem_d  = tag_mem_q;
    zero_mem_d = zero_mem_q;
    if (push) begin
      data_mem_d[wr_ptr_q] = alu_c;
      tag_mem_d[wr_ptr_q]  = s2_tag_q;
      zero_mem_d[wr_ptr_q] = (alu_c == 8'h00);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= '0;
      s1_v_q    <= 1'b0;
      s2_v_q    <= 1'b0;
      s1_tag_q  <= '0;
      s2_tag_q  <= '0;
      tag_cnt_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_op_q  <= alu_op_d;
      s1_v_q    <= s1_v_d;
      s2_v_q    <= s2_v_d;
      s1_tag_q  <= s1_tag_d;
      s2_tag_q  <= s2_tag_d;
      tag_cnt_q <= tag_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // Storage needs no reset: the head is only exposed while count is non-zero.
  always_ff @(posedge clk) begin
    data_mem_q <= data_mem_d;
    tag_mem_q  <= tag_mem_d;
    zero_mem_q <= zero_mem_d;
  end

  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_op   = alu_op_q;
  assign res_data = res_valid ? data_mem_q[rd_ptr_q] : 8'h00;
  assign res_tag  = res_valid ? tag_mem_q[rd_ptr_q]  : '0;
  assign res_zero = res_valid && zero_mem_q[rd_ptr_q];
  assign busy     = s1_v_q | s2_v_q | (count_q != '0);

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer with a behavioural registered ALU and an in-order scoreboard.
module tb_alu_cmd_issuer;
  localparam int RES_DEPTH = 4;
  localparam int TAG_W     = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid, cmd_ready;
  logic [7:0]       cmd_a, cmd_b;
  logic [1:0]       cmd_op;
  logic [7:0]       alu_a, alu_b, alu_c;
  logic [1:0]       alu_op;
  logic             res_valid, res_ready, res_zero, busy;
  logic [7:0]       res_data;
  logic [TAG_W-1:0] res_tag;

  alu_cmd_issuer #(.RES_DEPTH(RES_DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_tag(res_tag), .res_zero(res_zero),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Registered ALU, no reset.
  always @(posedge clk) begin
    case (alu_op)
      2'd0:    alu_c <= alu_a + alu_b;
      2'd1:    alu_c <= alu_a - alu_b;
      2'd2:    alu_c <= alu_a & alu_b;
      default: alu_c <= alu_a | alu_b;
    endcase
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    logic [7:0] exp;
  } vec_t;

  typedef struct packed {
    logic [7:0]       data;
    logic [TAG_W-1:0] tag;
    logic             zero;
  } exp_t;

  vec_t             tbl [6];
  exp_t             sb_q [$];
  logic [TAG_W-1:0] tag_log [$];
  logic [TAG_W-1:0] tb_tag;
  logic [7:0]       drv_exp;
  int               n_tests = 0;
  int               n_fail  = 0;
  int               n_popped = 0;
  bit               acc;

  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [1:0] op);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a | b;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard update, called on the falling edge before each rising edge.
  task automatic mon();
    exp_t e;
    acc = 1'b0;
    if (!rst_n) begin
      sb_q.delete();
      tb_tag = '0;
    end else begin
      if (res_valid && res_ready) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_unexpected: got result %0h tag %0d, expected none", res_data, res_tag);
        end else begin
          e = sb_q.pop_front();
          check("sb_data", 32'(res_data), 32'(e.data));
          check("sb_tag",  32'(res_tag),  32'(e.tag));
          check("sb_zero", 32'(res_zero), 32'(e.zero));
          tag_log.push_back(res_tag);
          n_popped++;
        end
      end
      if (cmd_valid && cmd_ready) begin
        sb_q.push_back('{data: drv_exp, tag: tb_tag, zero: (drv_exp == 8'h00)});
        tb_tag = tb_tag + TAG_W'(1);
        acc = 1'b1;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                         input logic [7:0] exp);
    cmd_a = a; cmd_b = b; cmd_op = op; drv_exp = exp; cmd_valid = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic drain(input string name, input int budget);
    int left;
    left = budget;
    while ((sb_q.size() != 0 || busy) && left > 0) begin
      step();
      left--;
    end
    if (left == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: drain timeout, %0d results outstanding, expected 0", name, sb_q.size());
    end
  endtask

  initial begin
    int idx, pops0;
    cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; drv_exp = '0;
    res_ready = 1'b1; tb_tag = '0;

    tbl[0] = '{a: 8'd7, b: 8'd3, op: 2'd0, exp: 8'd10};
    tbl[1] = '{a: 8'd7, b: 8'd3, op: 2'd1, exp: 8'd4};
    tbl[2] = '{a: 8'd7, b: 8'd3, op: 2'd2, exp: 8'd3};
    tbl[3] = '{a: 8'd7, b: 8'd3, op: 2'd3, exp: 8'd7};
    tbl[4] = '{a: 8'd3, b: 8'd7, op: 2'd1, exp: 8'hFC};
    tbl[5] = '{a: 8'd5, b: 8'd5, op: 2'd1, exp: 8'h00};

    // Reset state
    #2;
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_res_data",  32'(res_data),  32'd0);
    check("rst_res_tag",   32'(res_tag),   32'd0);
    check("rst_res_zero",  32'(res_zero),  32'd0);
    check("rst_alu_a",     32'(alu_a),     32'd0);
    check("rst_alu_op",    32'(alu_op),    32'd0);
    do_reset();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // Single command latency
    set_cmd(8'd7, 8'd3, 2'd0, 8'd10);
    step();
    cmd_valid = 1'b0;
    check("t1_alu_a",   32'(alu_a),  32'd7);
    check("t1_alu_b",   32'(alu_b),  32'd3);
    check("t1_alu_op",  32'(alu_op), 32'd0);
    check("t1_valid_e0", 32'(res_valid), 32'd0);
    step();
    check("t1_valid_e1", 32'(res_valid), 32'd0);
    step();
    check("t1_valid_e2", 32'(res_valid), 32'd1);
    check("t1_data",     32'(res_data),  32'd10);
    check("t1_tag",      32'(res_tag),   32'd0);
    check("t1_zero",     32'(res_zero),  32'd0);
    step();
    check("t1_valid_pop", 32'(res_valid), 32'd0);
    check("t1_busy_pop",  32'(busy),      32'd0);

    // Back-to-back table vectors, including wrap and zero results
    do_reset();
    for (int i = 0; i < 6; i++) begin
      set_cmd(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].exp);
      check("t2_cmd_ready", 32'(cmd_ready), 32'd1);
      step();
      check("t2_accept", 32'(acc), 32'd1);
    end
    cmd_valid = 1'b0;
    repeat (3) step();
    check("t2_throughput_left", 32'(sb_q.size()), 32'd0);
    drain("t2_drain", 10);

    // Backpressure: credit stops at RES_DEPTH, then drain and finish the rest
    do_reset();
    res_ready = 1'b0;
    idx = 0;
    pops0 = n_popped;
    repeat (10) begin
      if (idx < 6)
        set_cmd(8'(idx * 37 + 11), 8'(idx * 5 + 2), 2'(idx),
                alu_ref(8'(idx * 37 + 11), 8'(idx * 5 + 2), 2'(idx)));
      else
        cmd_valid = 1'b0;
      step();
      if (acc) idx++;
    end
    check("t4_accepted",  32'(idx),       32'd4);
    check("t4_cmd_ready", 32'(cmd_ready), 32'd0);
    check("t4_res_valid", 32'(res_valid), 32'd1);
    check("t4_held_data", 32'(res_data),  32'(alu_ref(8'd11, 8'd2, 2'd0)));
    check("t4_held_tag",  32'(res_tag),   32'd0);
    res_ready = 1'b1;
    for (int n = 0; n < 40 && (idx < 6 || sb_q.size() != 0 || busy); n++) begin
      if (idx < 6)
        set_cmd(8'(idx * 37 + 11), 8'(idx * 5 + 2), 2'(idx),
                alu_ref(8'(idx * 37 + 11), 8'(idx * 5 + 2), 2'(idx)));
      else
        cmd_valid = 1'b0;
      step();
      if (acc) idx++;
    end
    cmd_valid = 1'b0;
    check("t4_total_accepted", 32'(idx), 32'd6);
    check("t4_total_results",  32'(n_popped - pops0), 32'd6);

    // Tag wrap over 10 commands
    do_reset();
    tag_log.delete();
    for (int i = 0; i < 10; i++) begin
      cmd_a = 8'($urandom_range(0, 255));
      cmd_b = 8'($urandom_range(0, 255));
      cmd_op = 2'($urandom_range(0, 3));
      set_cmd(cmd_a, cmd_b, cmd_op, alu_ref(cmd_a, cmd_b, cmd_op));
      step();
    end
    cmd_valid = 1'b0;
    drain("t5_drain", 20);
    check("t5_count", 32'(tag_log.size()), 32'd10);
    for (int i = 0; i < 10 && i < tag_log.size(); i++)
      check("t5_tag_seq", 32'(tag_log[i]), 32'(i % 8));

    // Asynchronous reset with work in flight
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_cmd(8'(20 + i), 8'(i), 2'd0, 8'(20 + 2 * i));
      step();
      check("t6_accept", 32'(acc), 32'd1);
    end
    cmd_valid = 1'b0;
    check("t6_pre_valid", 32'(res_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_valid", 32'(res_valid), 32'd0);
    check("t6_async_busy",  32'(busy),      32'd0);
    check("t6_async_alu_a", 32'(alu_a),     32'd0);
    step();
    rst_n = 1'b1;
    check("t6_ready_after", 32'(cmd_ready), 32'd1);
    res_ready = 1'b1;
    repeat (4) begin
      step();
      check("t6_no_stale", 32'(res_valid), 32'd0);
    end
    tag_log.delete();
    set_cmd(8'd9, 8'd4, 2'd2, 8'd0);
    step();
    cmd_valid = 1'b0;
    drain("t6_drain", 10);
    check("t6_count", 32'(tag_log.size()), 32'd1);
    if (tag_log.size() > 0)
      check("t6_tag", 32'(tag_log[0]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
